// File: rtl/boot_run_sequencer.sv
// Run-control sequencer: latches boot straps, sequences the SoC reset and optional
// firmware preload, then supervises the run until an exit or a watchdog timeout.
module boot_run_sequencer #(
    parameter int RESET_WAIT_CYCLES = 50,
    parameter bit JTAG_DPI          = 1'b0,
    parameter int CNT_W             = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             boot_select_i,
    input  logic             execute_from_flash_i,
    input  logic             load_done_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    input  logic [CNT_W-1:0] maxcycles_i,
    output logic             soc_rst_no,
    output logic             boot_select_o,
    output logic             execute_from_flash_o,
    output logic             load_req_o,
    output logic             exit_loop_o,
    output logic             done_o,
    output logic             pass_o,
    output logic             timeout_o,
    output logic [31:0]      exit_code_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RST_HOLD  = 3'd1,
        S_POST_WAIT = 3'd2,
        S_LOAD      = 3'd3,
        S_EXIT_LOOP = 3'd4,
        S_RUN       = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [31:0]      WAIT_LAST = 32'(RESET_WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_nextState;
    logic [31:0]       r_waitCnt;
    logic [31:0]       w_waitCntNext;

    logic              r_socRstN;
    logic              r_bootSel;
    logic              r_execFlash;
    logic              r_loadReq;
    logic              r_exitLoop;
    logic              r_done;
    logic              r_pass;
    logic              r_timeout;
    logic [31:0]       r_exitCode;
    logic [CNT_W-1:0]  r_cycleCnt;

    logic              w_bootSelNext;
    logic              w_execFlashNext;
    logic              w_doneNext;
    logic              w_passNext;
    logic              w_timeoutNext;
    logic [31:0]       w_exitCodeNext;
    logic [CNT_W-1:0]  w_cycleCntNext;

    logic              w_startOk;
    logic              w_waitDone;
    logic              w_wdExpired;
    logic              w_exitTaken;

    assign w_startOk   = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_waitDone  = (r_waitCnt == WAIT_LAST);
    assign w_wdExpired = (maxcycles_i != '0) && (r_cycleCnt >= maxcycles_i);
    assign w_exitTaken = (r_state == S_RUN) && exit_valid_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_waitCntNext;
        end
    end

    // Watchdog takes priority everywhere except over an exit seen in RUN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:      if (start_i) w_nextState = S_RST_HOLD;
            S_RST_HOLD:  if (w_waitDone) w_nextState = S_POST_WAIT;
            S_POST_WAIT: begin
                if (w_wdExpired)
                    w_nextState = S_DONE;
                else if (w_waitDone)
                    w_nextState = (!r_bootSel && !JTAG_DPI) ? S_LOAD : S_RUN;
            end
            S_LOAD: begin
                if (w_wdExpired)      w_nextState = S_DONE;
                else if (load_done_i) w_nextState = S_EXIT_LOOP;
            end
            S_EXIT_LOOP: w_nextState = w_wdExpired ? S_DONE : S_RUN;
            S_RUN:       if (exit_valid_i || w_wdExpired) w_nextState = S_DONE;
            S_DONE:      if (start_i) w_nextState = S_RST_HOLD;
            default:     w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        w_waitCntNext = '0;
        if (!w_startOk && ((r_state == S_RST_HOLD) || (r_state == S_POST_WAIT)))
            w_waitCntNext = w_waitDone ? '0 : r_waitCnt + 32'd1;
    end

    always_comb begin
        w_bootSelNext   = r_bootSel;
        w_execFlashNext = r_execFlash;
        w_doneNext      = r_done;
        w_passNext      = r_pass;
        w_timeoutNext   = r_timeout;
        w_exitCodeNext  = r_exitCode;
        w_cycleCntNext  = r_cycleCnt;
        if (w_startOk) begin
            w_bootSelNext   = boot_select_i;
            w_execFlashNext = boot_select_i & execute_from_flash_i;
            w_doneNext      = 1'b0;
            w_passNext      = 1'b0;
            w_timeoutNext   = 1'b0;
            w_exitCodeNext  = '0;
            w_cycleCntNext  = '0;
        end else begin
            if (w_exitTaken) begin
                w_exitCodeNext = exit_value_i;
                w_passNext     = (exit_value_i == 32'd0);
                w_doneNext     = 1'b1;
            end else if ((w_nextState == S_DONE) && (r_state != S_DONE)) begin
                w_timeoutNext = 1'b1;
                w_doneNext    = 1'b1;
                w_passNext    = 1'b0;
            end
            if (r_socRstN && (r_state != S_DONE) && (r_cycleCnt != CNT_MAX))
                w_cycleCntNext = r_cycleCnt + CNT_ONE;
        end
    end

    // Pin-level outputs are registered from the next state so they line up with state_o.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_socRstN   <= 1'b0;
            r_loadReq   <= 1'b0;
            r_exitLoop  <= 1'b0;
            r_bootSel   <= 1'b0;
            r_execFlash <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_exitCode  <= '0;
            r_cycleCnt  <= '0;
        end else begin
            r_socRstN   <= (w_nextState != S_IDLE) && (w_nextState != S_RST_HOLD);
            r_loadReq   <= (w_nextState == S_LOAD);
            r_exitLoop  <= (w_nextState == S_EXIT_LOOP);
            r_bootSel   <= w_bootSelNext;
            r_execFlash <= w_execFlashNext;
            r_done      <= w_doneNext;
            r_pass      <= w_passNext;
            r_timeout   <= w_timeoutNext;
            r_exitCode  <= w_exitCodeNext;
            r_cycleCnt  <= w_cycleCntNext;
        end
    end

    assign soc_rst_no           = r_socRstN;
    assign boot_select_o        = r_bootSel;
    assign execute_from_flash_o = r_execFlash;
    assign load_req_o           = r_loadReq;
    assign exit_loop_o          = r_exitLoop;
    assign done_o               = r_done;
    assign pass_o               = r_pass;
    assign timeout_o            = r_timeout;
    assign exit_code_o          = r_exitCode;
    assign cycle_cnt_o          = r_cycleCnt;
    assign state_o              = r_state;

endmodule

// File: tb/tb_boot_run_sequencer.sv
// Randomized bench for boot_run_sequencer: each run's expected timeline is derived
// from its chosen load/exit/watchdog times and compared cycle by cycle.
module tb_boot_run_sequencer;

    localparam int N  = 4;
    localparam int CW = 32;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          bsel = 1'b0;
    logic          eff = 1'b0;
    logic          ldone = 1'b0;
    logic          ev = 1'b0;
    logic [31:0]   evalue = '0;
    logic [CW-1:0] maxc = '0;

    logic          socRstN;
    logic          bselO;
    logic          effO;
    logic          loadReq;
    logic          exitLoop;
    logic          done;
    logic          pass;
    logic          timeout;
    logic [31:0]   exitCode;
    logic [CW-1:0] cycleCnt;
    logic [2:0]    state;

    int nCompared = 0;
    int nMismatched = 0;

    boot_run_sequencer #(
        .RESET_WAIT_CYCLES(N),
        .JTAG_DPI(1'b0),
        .CNT_W(CW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_i(start),
        .boot_select_i(bsel),
        .execute_from_flash_i(eff),
        .load_done_i(ldone),
        .exit_valid_i(ev),
        .exit_value_i(evalue),
        .maxcycles_i(maxc),
        .soc_rst_no(socRstN),
        .boot_select_o(bselO),
        .execute_from_flash_o(effO),
        .load_req_o(loadReq),
        .exit_loop_o(exitLoop),
        .done_o(done),
        .pass_o(pass),
        .timeout_o(timeout),
        .exit_code_o(exitCode),
        .cycle_cnt_o(cycleCnt),
        .state_o(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL globalTimeout: got running expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".socRstN"}, 32'(socRstN), 0);
        checkOutput({tag, ".bselO"}, 32'(bselO), 0);
        checkOutput({tag, ".effO"}, 32'(effO), 0);
        checkOutput({tag, ".loadReq"}, 32'(loadReq), 0);
        checkOutput({tag, ".exitLoop"}, 32'(exitLoop), 0);
        checkOutput({tag, ".done"}, 32'(done), 0);
        checkOutput({tag, ".pass"}, 32'(pass), 0);
        checkOutput({tag, ".timeout"}, 32'(timeout), 0);
        checkOutput({tag, ".exitCode"}, exitCode, 0);
        checkOutput({tag, ".cycleCnt"}, cycleCnt, 0);
        checkOutput({tag, ".state"}, 32'(state), 0);
    endtask

    function automatic int runStart(input bit bs, input int d);
        if (bs) return N;
        return (d < 0) ? NEVER : N + d + 2;
    endfunction

    // d: load_done delay after LOAD entry (-1 never); e: exit cycle after release (-1 never);
    // m: watchdog limit; abortAt: cycle after release at which to hand control back early.
    task automatic applyStimulus(input bit bs, input bit ef, input int d, input int e,
                                 input int m, input logic [31:0] v, input int abortAt);
        int  rs;
        int  f;
        bit  exitWins;
        bit  loadPath;
        loadPath = !bs;
        rs = runStart(bs, d);
        if (m != 0 && m < rs) begin
            exitWins = 1'b0; f = m;
        end else if (e >= 0 && rs < NEVER && (m == 0 || e <= m)) begin
            exitWins = 1'b1; f = e;
        end else begin
            exitWins = 1'b0; f = m;
        end
        maxc  = CW'(m);
        bsel  = bs;
        eff   = ef;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 0; j < N + f + 4; j++) begin
            int          c;
            int          expState;
            int          expCnt;
            bit          expSoc;
            bit          expDone;
            bit          expPass;
            bit          expTo;
            logic [31:0] expCode;
            string       at;
            c = j - N;
            if (c == abortAt) return;
            expPass = 1'b0; expTo = 1'b0; expCode = '0; expDone = 1'b0;
            if (c < 0) begin
                expState = 1; expSoc = 1'b0; expCnt = 0;
            end else if (c <= f) begin
                expSoc = 1'b1; expCnt = c;
                if (c < N)                          expState = 2;
                else if (!loadPath)                 expState = 5;
                else if (d < 0 || c <= N + d)       expState = 3;
                else if (c == N + d + 1)            expState = 4;
                else                                expState = 5;
            end else begin
                expState = 6; expSoc = 1'b1; expCnt = f + 1; expDone = 1'b1;
                expPass = exitWins && (v == 0);
                expTo   = !exitWins;
                expCode = exitWins ? v : 32'd0;
            end
            at = $sformatf("c%0d", c);
            checkOutput({at, ".state"}, 32'(state), 32'(expState));
            checkOutput({at, ".socRstN"}, 32'(socRstN), 32'(expSoc));
            checkOutput({at, ".loadReq"}, 32'(loadReq), 32'(expState == 3));
            checkOutput({at, ".exitLoop"}, 32'(exitLoop), 32'(expState == 4));
            checkOutput({at, ".cycleCnt"}, cycleCnt, 32'(expCnt));
            checkOutput({at, ".done"}, 32'(done), 32'(expDone));
            checkOutput({at, ".pass"}, 32'(pass), 32'(expPass));
            checkOutput({at, ".timeout"}, 32'(timeout), 32'(expTo));
            checkOutput({at, ".exitCode"}, exitCode, expCode);
            checkOutput({at, ".bselO"}, 32'(bselO), 32'(bs));
            checkOutput({at, ".effO"}, 32'(effO), 32'(bs & ef));

            // Out-of-window pulses on load_done/exit_valid/start must all be ignored.
            if (loadPath && d >= 0 && c == N + d) ldone = 1'b1;
            else ldone = (expState != 3) && ($urandom % 4 == 0);
            if (c == e) begin
                ev = 1'b1; evalue = v;
            end else if (expState != 5 && ($urandom % 4 == 0)) begin
                ev = 1'b1; evalue = $urandom;
            end else begin
                ev = 1'b0;
            end
            start = (expState >= 1 && expState <= 5) && ($urandom % 5 == 0);
            bsel  = 1'($urandom);
            eff   = 1'($urandom);
            @(posedge clk); #1;
        end
        ldone = 1'b0; ev = 1'b0; start = 1'b0;
    endtask

    initial begin
        int bs; int d; int e; int m; int rs;
        logic [31:0] v;
        $display("[TB] boot_run_sequencer bench start");
        #1;
        checkAllZero("reset");
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle.state", 32'(state), 0);
        checkOutput("idle.socRstN", 32'(socRstN), 0);

        applyStimulus(1'b0, 1'b1, 3, 19, 0, 32'd0, NEVER);
        applyStimulus(1'b1, 1'b1, -1, N + 6, 0, 32'd5, NEVER);
        applyStimulus(1'b0, 1'b0, -1, -1, 20, 32'd0, NEVER);
        applyStimulus(1'b1, 1'b0, -1, 12, 12, 32'd0, NEVER);

        applyStimulus(1'b0, 1'b1, -1, -1, 200, 32'd0, N + 1);
        ldone = 1'b0; ev = 1'b0; start = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkAllZero("asyncReset");
        @(posedge clk); #1;
        checkAllZero("heldReset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("postReset.state", 32'(state), 0);
        applyStimulus(1'b0, 1'b1, 1, 10, 0, 32'd7, NEVER);
        applyStimulus(1'b1, 1'b1, -1, 6, 0, 32'd0, NEVER);

        for (int r = 0; r < 24; r++) begin
            bs = $urandom % 2;
            d  = ($urandom % 4 == 0) ? -1 : int'($urandom % 6);
            m  = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 40));
            rs = runStart(bs[0], d);
            if (rs < NEVER && ($urandom % 4 != 0)) e = rs + int'($urandom % 12);
            else e = -1;
            if (m == 0 && e < 0) m = int'($urandom_range(5, 40));
            v = ($urandom % 2 == 0) ? 32'd0 : $urandom;
            if ($urandom % 5 == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
                @(posedge clk); #1;
            end
            applyStimulus(bs[0], 1'($urandom), d, e, m, v, NEVER);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
